sat_accumulator: RTL and testbench
==================================

Name: sat_accumulator

Overview:
- Synchronous, unsigned, saturating running-sum accumulator.
- Each clock it adds an 8-bit input sample to a 16-bit registered total, clamping at all-ones instead of wrapping.
- Used as a leaf datapath block wherever a bounded byte-stream sum is needed; no handshake, one sample accepted every cycle.

Parameters:
- DATA_W, 8, width of input sample data_in (unsigned).
- SUM_W, 16, width of accumulated output sum (unsigned); must satisfy SUM_W > DATA_W.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  DATA_W  unsigned sample added every cycle rst is low.
- sum  output  SUM_W  registered accumulated total, saturating at 2^SUM_W-1.
- sat  output  1  present only with SAT_FLAG_EN; sticky saturation indicator.

Behaviour:
- Reset: at a posedge with rst=1, sum <= 0 (and sat <= 0 when present). rst is sampled only at clock edges; no asynchronous path.
- Reset priority: rst=1 overrides accumulation in the same cycle; data_in is ignored that cycle.
- Reset mid-operation: the next edge with rst=1 clears sum regardless of its value. Accumulation resumes from 0 on the first edge with rst=0, adding that edge's data_in.
- Accumulate: at a posedge with rst=0, compute next = sum + data_in in SUM_W+1 bits (zero-extended operands).
- Saturation: if next > 2^SUM_W-1 then sum <= 2^SUM_W-1 (16'hFFFF default); else sum <= next[SUM_W-1:0].
- Once saturated, sum holds at max for all further data_in values, including 0, until reset. There is no wrap-around.
- Latency: data_in sampled at edge N is reflected in sum immediately after edge N (1-cycle registered latency).
- sum is driven directly from the register; no combinational path from data_in to sum.
- data_in = 0 leaves sum unchanged.
- All arithmetic is unsigned; no signed interpretation of data_in.
- Before the first reset, sum is undefined. Benches must assert rst for at least one edge.

Optional Feature:
- Macro: SAT_FLAG_EN.
- Defined: adds output port sat.
  - sat <= 0 on reset.
  - sat <= 1 on the first accumulate edge where the unclamped next exceeds 2^SUM_W-1; it then stays 1 (sticky) until reset.
  - sat equals 0 when sum reaches exactly max without overflow.
- Undefined: port sat and its register do not exist; sum behaviour is identical.

Decomposition:
- Shared package acc_pkg holds:
  - default width constants ACC_DATA_W=8 and ACC_SUM_W=16;
  - constant ACC_SUM_MAX (all-ones of SUM_W);
  - typedefs acc_data_t and acc_sum_t.
- A sub-module sat_adder (combinational add-and-clamp: inputs a, b; outputs result, ovf) is natural and reusable. The top holds only the sum/sat registers and reset logic.
- A companion SystemVerilog interface acc_if (clk as port; rst, data_in, sum, sat as signals) bundles the DUT pins for benches.

Test Plan:
- Reset: drive sum nonzero, assert rst=1 for one edge -> sum=16'h0000 after that edge; sat=0.
- Basic accumulate: after reset, data_in sequence 8'h01, 8'h02, 8'hFF on consecutive edges -> sum 16'h0001, 16'h0003, 16'h0102.
- Saturation boundary: preload to 16'hFF00 via 256 edges of 8'hFF, then data_in=8'hFF -> sum=16'hFFFF (no wrap). Further 8'h01 -> stays 16'hFFFF; sat=1 when SAT_FLAG_EN.
- Exact max: reach 16'hFFFF exactly without overflow -> sum=16'hFFFF, sat=0. Next nonzero input -> sat=1, sum unchanged.
- Reset priority: rst=1 with data_in=8'h55 on the same edge -> sum=0. Next edge, rst=0 with data_in=8'h55 -> sum=16'h0055.
- Random stream: 500 random bytes, rst low throughout after initial reset -> each cycle sum equals min(running reference sum, 16'hFFFF).

Source files
------------

// File: rtl/acc_pkg.sv
// Shared widths, limits and types for the saturating accumulator.
package acc_pkg;

  localparam int unsigned ACC_DATA_W = 8;
  localparam int unsigned ACC_SUM_W  = 16;

  typedef logic [ACC_DATA_W-1:0] acc_data_t;
  typedef logic [ACC_SUM_W-1:0]  acc_sum_t;

  localparam acc_sum_t ACC_SUM_MAX = {ACC_SUM_W{1'b1}};

endpackage

// File: rtl/acc_if.sv
// Pin bundle for the saturating accumulator at its default widths.
// The sat signal exists only when SAT_FLAG_EN is defined, matching the DUT.
interface acc_if
  import acc_pkg::*;
(
  input logic clk
);

  logic      rst;
  acc_data_t data_in;
  acc_sum_t  sum;
`ifdef SAT_FLAG_EN
  logic      sat;
`endif

endinterface

// File: rtl/sat_adder.sv
// Combinational unsigned add-and-clamp: result = min(a + b, all-ones), ovf flags clamping.
module sat_adder #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SUM_W  = 16
) (
  input  logic [SUM_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [SUM_W-1:0]  result,
  output logic              ovf
);

  logic [SUM_W:0] full;

  // One extra bit catches the carry out; a set carry means the true sum exceeds max.
  always_comb begin
    full   = {1'b0, a} + {{(SUM_W + 1 - DATA_W){1'b0}}, b};
    ovf    = full[SUM_W];
    result = ovf ? {SUM_W{1'b1}} : full[SUM_W-1:0];
  end

endmodule

// File: rtl/sat_accumulator.sv
// Unsigned saturating running-sum accumulator, one sample per clock, 1-cycle latency.
// Define SAT_FLAG_EN to add the sticky saturation output sat.
module sat_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = ACC_DATA_W,
  parameter int unsigned SUM_W  = ACC_SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  output logic [SUM_W-1:0]  sum
`ifdef SAT_FLAG_EN
  ,
  output logic              sat
`endif
);

  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

`ifdef SAT_FLAG_EN
  logic ovf;
  logic sat_q;
`else
  logic unused_ovf;
`endif

  sat_adder #(
    .DATA_W(DATA_W),
    .SUM_W (SUM_W)
  ) u_sat_adder (
    .a     (sum_q),
    .b     (data_in),
    .result(sum_d),
`ifdef SAT_FLAG_EN
    .ovf   (ovf)
`else
    .ovf   (unused_ovf)
`endif
  );

  // Running total; reset wins over accumulation on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

`ifdef SAT_FLAG_EN
  // Sticky flag: set only by a real overflow, so landing exactly on max leaves it clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
    end else if (ovf) begin
      sat_q <= 1'b1;
    end
  end

  assign sat = sat_q;
`endif

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed and random-stream bench for sat_accumulator; sat checks apply when SAT_FLAG_EN is set.
module tb_sat_accumulator;
  import acc_pkg::*;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  acc_if u_if (.clk(clk));

  sat_accumulator u_dut (
    .clk    (clk),
    .rst    (u_if.rst),
    .data_in(u_if.data_in),
    .sum    (u_if.sum)
`ifdef SAT_FLAG_EN
    ,
    .sat    (u_if.sat)
`endif
  );

  // Apply inputs for one rising edge, then settle 1 time unit past it.
  task automatic step(input logic r, input logic [7:0] d);
    u_if.rst     = r;
    u_if.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 8'h00);
    checks++;
    if (u_if.sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_initial: sum=%h expected 0000", u_if.sum);
    end
    step(1'b0, 8'h40);
    checks++;
    if (u_if.sum !== 16'h0040) begin
      errors++;
      $display("FAIL reset_preload: sum=%h expected 0040", u_if.sum);
    end
    step(1'b1, 8'h00);
    checks++;
    if (u_if.sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_clear: sum=%h expected 0000", u_if.sum);
    end
`ifdef SAT_FLAG_EN
    checks++;
    if (u_if.sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_sat: sat=%b expected 0", u_if.sat);
    end
`endif
  endtask

  task automatic test_accumulate();
    logic [7:0]  din [4];
    logic [15:0] exp [4];
    din = '{8'h01, 8'h02, 8'hFF, 8'h00};
    exp = '{16'h0001, 16'h0003, 16'h0102, 16'h0102};
    step(1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, din[i]);
      checks++;
      if (u_if.sum !== exp[i]) begin
        errors++;
        $display("FAIL accumulate[%0d]: sum=%h expected %h", i, u_if.sum, exp[i]);
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 8'h00);
    for (int i = 0; i < 256; i++) step(1'b0, 8'hFF);
    checks++;
    if (u_if.sum !== 16'hFF00) begin
      errors++;
      $display("FAIL sat_preload: sum=%h expected ff00", u_if.sum);
    end
    // 0xFF00 + 0xFF lands exactly on max: no overflow yet.
    step(1'b0, 8'hFF);
    checks++;
    if (u_if.sum !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: sum=%h expected ffff", u_if.sum);
    end
`ifdef SAT_FLAG_EN
    checks++;
    if (u_if.sat !== 1'b0) begin
      errors++;
      $display("FAIL sat_reach_flag: sat=%b expected 0", u_if.sat);
    end
`endif
    step(1'b0, 8'h01);
    checks++;
    if (u_if.sum !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: sum=%h expected ffff", u_if.sum);
    end
    step(1'b0, 8'hFF);
    checks++;
    if (u_if.sum !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_no_wrap: sum=%h expected ffff", u_if.sum);
    end
    step(1'b0, 8'h00);
    checks++;
    if (u_if.sum !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_zero: sum=%h expected ffff", u_if.sum);
    end
`ifdef SAT_FLAG_EN
    checks++;
    if (u_if.sat !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: sat=%b expected 1", u_if.sat);
    end
`endif
  endtask

  task automatic test_exact_max();
    step(1'b1, 8'h00);
    for (int i = 0; i < 256; i++) step(1'b0, 8'hFF);
    step(1'b0, 8'h80);
    checks++;
    if (u_if.sum !== 16'hFF80) begin
      errors++;
      $display("FAIL exact_ff80: sum=%h expected ff80", u_if.sum);
    end
    step(1'b0, 8'h7F);
    step(1'b0, 8'h00);
    checks++;
    if (u_if.sum !== 16'hFFFF) begin
      errors++;
      $display("FAIL exact_max: sum=%h expected ffff", u_if.sum);
    end
`ifdef SAT_FLAG_EN
    checks++;
    if (u_if.sat !== 1'b0) begin
      errors++;
      $display("FAIL exact_max_flag: sat=%b expected 0", u_if.sat);
    end
`endif
    step(1'b0, 8'h02);
    checks++;
    if (u_if.sum !== 16'hFFFF) begin
      errors++;
      $display("FAIL exact_over: sum=%h expected ffff", u_if.sum);
    end
`ifdef SAT_FLAG_EN
    checks++;
    if (u_if.sat !== 1'b1) begin
      errors++;
      $display("FAIL exact_over_flag: sat=%b expected 1", u_if.sat);
    end
`endif
    step(1'b1, 8'h10);
    checks++;
    if (u_if.sum !== 16'h0000) begin
      errors++;
      $display("FAIL exact_reset: sum=%h expected 0000", u_if.sum);
    end
`ifdef SAT_FLAG_EN
    checks++;
    if (u_if.sat !== 1'b0) begin
      errors++;
      $display("FAIL exact_reset_flag: sat=%b expected 0", u_if.sat);
    end
`endif
  endtask

  task automatic test_reset_priority();
    step(1'b0, 8'h33);
    step(1'b1, 8'h55);
    checks++;
    if (u_if.sum !== 16'h0000) begin
      errors++;
      $display("FAIL prio_reset: sum=%h expected 0000", u_if.sum);
    end
    step(1'b0, 8'h55);
    checks++;
    if (u_if.sum !== 16'h0055) begin
      errors++;
      $display("FAIL prio_resume: sum=%h expected 0055", u_if.sum);
    end
  endtask

  task automatic test_random();
    int         ref_sum;
    bit         ref_sat;
    logic [7:0] d;
    int         bad;
    ref_sum = 0;
    ref_sat = 1'b0;
    bad     = 0;
    step(1'b1, 8'h00);
    for (int i = 0; i < 500; i++) begin
      d = 8'($urandom_range(0, 255));
      step(1'b0, d);
      ref_sum = ref_sum + int'(d);
      if (ref_sum > 65535) begin
        ref_sum = 65535;
        ref_sat = 1'b1;
      end
      checks++;
      if (u_if.sum !== 16'(ref_sum)) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d]: sum=%h expected %h", i, u_if.sum, 16'(ref_sum));
      end
`ifdef SAT_FLAG_EN
      checks++;
      if (u_if.sat !== ref_sat) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_sat[%0d]: sat=%b expected %b", i, u_if.sat, ref_sat);
      end
`endif
    end
  endtask

  initial begin
    u_if.rst     = 1'b1;
    u_if.data_in = '0;
    test_reset();
    test_accumulate();
    test_saturation();
    test_exact_max();
    test_reset_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
